// File: rtl/cluster_evt_fifo_pkg.sv
// Shared helpers for the cluster/SoC asynchronous event FIFO: Gray conversions
// and synchronizer depth limits.
package cluster_evt_fifo_pkg;

    localparam int unsigned MAX_PTR_WIDTH   = 32;
    localparam int unsigned MIN_SYNC_STAGES = 2;

    typedef logic [MAX_PTR_WIDTH-1:0] ptr_t;

    // Narrower pointers are zero-extended into ptr_t; the zero upper bits leave
    // both conversions exact for any width up to MAX_PTR_WIDTH.
    function automatic ptr_t bin2gray(input ptr_t bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t gray);
        ptr_t bin;
        bin = gray;
        for (int i = 1; i < MAX_PTR_WIDTH; i++) begin
            bin = bin ^ (gray >> i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/evt_ptr_sync.sv
// Multi-flop synchronizer for a Gray-coded pointer crossing into the local
// clock domain; all stages reset to zero.
module evt_ptr_sync #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    (* async_reg = "true" *) logic [WIDTH-1:0] sync_q [STAGES];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cluster_event_fifo_rx.sv
// Cluster-side read half of the async event FIFO. Optional pointer sanity
// check is enabled with CLUSTER_EVT_RX_PTR_CHECK_EN.
module cluster_event_fifo_rx
    import cluster_evt_fifo_pkg::*;
#(
    parameter int unsigned LOG_DEPTH   = 3,
    parameter int unsigned EVNT_WIDTH  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    input  logic [LOG_DEPTH:0]                          async_events_wptr_i,
    input  logic [2**LOG_DEPTH-1:0][EVNT_WIDTH-1:0]     async_events_data_i,
    output logic [LOG_DEPTH:0]                          async_events_rptr_o,
    output logic                                        evt_valid_o,
    output logic [EVNT_WIDTH-1:0]                       evt_data_o,
    input  logic                                        evt_ready_i,
    output logic [LOG_DEPTH:0]                          fill_o,
    output logic                                        ptr_err_o
);

    localparam int unsigned DEPTH = 2**LOG_DEPTH;
    localparam int unsigned PW    = LOG_DEPTH + 1;
    // Fewer than two stages is not a safe synchronizer, so clamp upward.
    localparam int unsigned SYNC_DEPTH =
        (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;

    logic [PW-1:0]         wgray_s;
    logic [PW-1:0]         wbin_s;
    logic [PW-1:0]         rbin;
    logic [PW-1:0]         rbin_next;
    logic [PW-1:0]         rgray;
    logic [PW-1:0]         fill_calc;
    logic [PW-1:0]         fill_q;
    logic                  empty;
    logic                  pop;
    logic                  out_valid;
    logic [EVNT_WIDTH-1:0] out_data;

    evt_ptr_sync #(
        .WIDTH  (PW),
        .STAGES (SYNC_DEPTH)
    ) u_wptr_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (async_events_wptr_i),
        .q_o    (wgray_s)
    );

    assign wbin_s    = PW'(gray2bin(ptr_t'(wgray_s)));
    assign empty     = (wgray_s == rgray);
    assign pop       = !empty && (!out_valid || evt_ready_i);
    assign rbin_next = pop ? rbin + PW'(1) : rbin;
    assign fill_calc = wbin_s - rbin;

    // rgray is derived from rbin_next so both pointers advance on the same edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rbin   <= '0;
            rgray  <= '0;
            fill_q <= '0;
        end else begin
            rbin   <= rbin_next;
            rgray  <= PW'(bin2gray(ptr_t'(rbin_next)));
            fill_q <= fill_calc;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (pop) begin
            out_valid <= 1'b1;
            out_data  <= async_events_data_i[rbin[LOG_DEPTH-1:0]];
        end else if (evt_ready_i && out_valid) begin
            out_valid <= 1'b0;
        end
    end

`ifdef CLUSTER_EVT_RX_PTR_CHECK_EN
    logic ptr_err_q;

    // A correct writer never runs more than DEPTH entries ahead of us.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_err_q <= 1'b0;
        end else if (fill_calc > PW'(DEPTH)) begin
            ptr_err_q <= 1'b1;
        end
    end

    assign ptr_err_o = ptr_err_q;
`else
    assign ptr_err_o = 1'b0;
`endif

    assign async_events_rptr_o = rgray;
    assign evt_valid_o         = out_valid;
    assign evt_data_o          = out_data;
    assign fill_o              = fill_q;

endmodule

// File: tb/tb_cluster_event_fifo_rx.sv
// Directed bench for cluster_event_fifo_rx with a behavioural SoC-side writer
// sharing the cluster clock.
module tb_cluster_event_fifo_rx;

    logic            clk;
    logic            rst_n;
    logic [3:0]      wptr;
    logic [7:0][7:0] wr_data;
    logic [3:0]      rptr;
    logic            evt_valid;
    logic [7:0]      evt_data;
    logic            evt_ready;
    logic [3:0]      fill;
    logic            ptr_err;

    int checks   = 0;
    int failures = 0;

    logic [3:0] wr_bin;
    logic       exp_err;

    cluster_event_fifo_rx #(
        .LOG_DEPTH   (3),
        .EVNT_WIDTH  (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .async_events_wptr_i (wptr),
        .async_events_data_i (wr_data),
        .async_events_rptr_o (rptr),
        .evt_valid_o         (evt_valid),
        .evt_data_o          (evt_data),
        .evt_ready_i         (evt_ready),
        .fill_o              (fill),
        .ptr_err_o           (ptr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] gray4(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [3:0] bin4(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        b[2] = b[3] ^ g[2];
        b[1] = b[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

    task automatic push(input logic [7:0] v);
        wr_data[wr_bin[2:0]] = v;
        wr_bin = wr_bin + 4'd1;
        wptr   = gray4(wr_bin);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        evt_ready = 1'b0;
        wr_bin    = 4'd0;
        wptr      = 4'd0;
        wr_data   = '0;
        repeat (2) @(negedge clk);
        checks++; if (evt_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", evt_valid); end
        checks++; if (evt_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_data got=%h exp=00", evt_data); end
        checks++; if (rptr !== 4'h0) begin failures++; $display("[TB] FAIL reset_rptr got=%h exp=0", rptr); end
        checks++; if (fill !== 4'h0) begin failures++; $display("[TB] FAIL reset_fill got=%h exp=0", fill); end
        checks++; if (ptr_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got=%b exp=0", ptr_err); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_event();
        push(8'hA5);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checks++;
            if (evt_valid !== (c == 3)) begin
                failures++; $display("[TB] FAIL single_latency edge=%0d got=%b exp=%b", c, evt_valid, (c == 3));
            end
        end
        checks++; if (evt_data !== 8'hA5) begin failures++; $display("[TB] FAIL single_data got=%h exp=a5", evt_data); end
        checks++; if (rptr !== 4'b0001) begin failures++; $display("[TB] FAIL single_rptr got=%b exp=0001", rptr); end
        evt_ready = 1'b1;
        @(negedge clk);
        checks++; if (evt_valid !== 1'b0) begin failures++; $display("[TB] FAIL single_drain got=%b exp=0", evt_valid); end
        checks++; if (fill !== 4'd0) begin failures++; $display("[TB] FAIL single_fill got=%0d exp=0", fill); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got [16];
        int n = 0, first = -1, last = -1, max_fill = 0;
        evt_ready = 1'b1;
        for (int i = 0; i < 8; i++) push(8'(i));
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (int'(fill) > max_fill) max_fill = int'(fill);
            if (evt_valid === 1'b1) begin
                if (first < 0) first = c;
                last = c;
                if (n < 16) got[n] = evt_data;
                n++;
            end
        end
        checks++; if (n != 8) begin failures++; $display("[TB] FAIL burst_count got=%0d exp=8", n); end
        checks++; if (last - first != 7) begin failures++; $display("[TB] FAIL burst_span got=%0d exp=7", last - first); end
        for (int i = 0; i < 8 && i < n; i++) begin
            checks++;
            if (got[i] !== 8'(i)) begin failures++; $display("[TB] FAIL burst_data idx=%0d got=%h exp=%h", i, got[i], 8'(i)); end
        end
        checks++; if (max_fill != 8) begin failures++; $display("[TB] FAIL burst_fill_peak got=%0d exp=8", max_fill); end
        checks++; if (fill !== 4'd0) begin failures++; $display("[TB] FAIL burst_fill_end got=%0d exp=0", fill); end
    endtask

    task automatic test_backpressure();
        evt_ready = 1'b0;
        push(8'h10); push(8'h11); push(8'h12);
        repeat (3) @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (evt_valid !== 1'b1 || evt_data !== 8'h10) begin
                failures++; $display("[TB] FAIL bp_hold cyc=%0d valid=%b data=%h exp=1/10", c, evt_valid, evt_data);
            end
            @(negedge clk);
        end
        checks++; if (fill !== 4'd2) begin failures++; $display("[TB] FAIL bp_fill got=%0d exp=2", fill); end
        evt_ready = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            checks++;
            if (evt_valid !== 1'b1 || evt_data !== 8'(8'h10 + k)) begin
                failures++; $display("[TB] FAIL bp_release k=%0d valid=%b data=%h exp=1/%h", k, evt_valid, evt_data, 8'(8'h10 + k));
            end
        end
        @(negedge clk);
        checks++; if (evt_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_empty got=%b exp=0", evt_valid); end
    endtask

    task automatic test_wrap_around();
        int sent = 0, rcv = 0, cyc = 0;
        logic [7:0] next_exp = 8'h40;
        logic [3:0] occ;
        evt_ready = 1'b1;
        while (rcv < 40 && cyc < 400) begin
            @(negedge clk);
            if (evt_valid === 1'b1 && evt_ready) begin
                checks++;
                if (evt_data !== next_exp) begin
                    failures++; $display("[TB] FAIL wrap_data idx=%0d got=%h exp=%h", rcv, evt_data, next_exp);
                end
                next_exp = next_exp + 8'd1;
                rcv++;
            end
            evt_ready = (cyc % 4) != 3;
            for (int k = 0; k < 3; k++) begin
                occ = wr_bin - bin4(rptr);
                if (sent < 40 && occ < 4'd8) begin
                    push(8'(8'h40 + sent));
                    sent++;
                end
            end
            cyc++;
        end
        checks++; if (rcv != 40) begin failures++; $display("[TB] FAIL wrap_count got=%0d exp=40", rcv); end
        evt_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (evt_valid !== 1'b0) begin failures++; $display("[TB] FAIL wrap_extra got=%b exp=0", evt_valid); end
        checks++; if (rptr !== gray4(wr_bin)) begin failures++; $display("[TB] FAIL wrap_rptr got=%b exp=%b", rptr, gray4(wr_bin)); end
    endtask

    task automatic test_reset_mid_stream();
        evt_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(8'(8'h20 + i));
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (evt_valid !== 1'b0 || evt_data !== 8'h00 || rptr !== 4'h0 || fill !== 4'h0 || ptr_err !== 1'b0) begin
            failures++; $display("[TB] FAIL midreset_async valid=%b data=%h rptr=%h fill=%h err=%b exp=all0", evt_valid, evt_data, rptr, fill, ptr_err);
        end
        wr_bin = 4'd0;
        wptr   = 4'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (evt_valid !== 1'b0 || fill !== 4'd0 || evt_data !== 8'h00) begin
            failures++; $display("[TB] FAIL midreset_idle valid=%b fill=%h data=%h exp=0/0/00", evt_valid, fill, evt_data);
        end
        push(8'h3C);
        repeat (3) @(negedge clk);
        checks++;
        if (evt_valid !== 1'b1 || evt_data !== 8'h3C) begin
            failures++; $display("[TB] FAIL midreset_new valid=%b data=%h exp=1/3c", evt_valid, evt_data);
        end
        evt_ready = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_ptr_check();
`ifdef CLUSTER_EVT_RX_PTR_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        rst_n     = 1'b0;
        evt_ready = 1'b0;
        wr_bin    = 4'd0;
        wptr      = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wptr = gray4(4'd12);
        repeat (2) @(negedge clk);
        checks++; if (ptr_err !== 1'b0) begin failures++; $display("[TB] FAIL ptrchk_early got=%b exp=0", ptr_err); end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (ptr_err !== exp_err) begin failures++; $display("[TB] FAIL ptrchk_sticky cyc=%0d got=%b exp=%b", c, ptr_err, exp_err); end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (ptr_err !== 1'b0) begin failures++; $display("[TB] FAIL ptrchk_reset got=%b exp=0", ptr_err); end
        wptr = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_back_to_back();
        test_backpressure();
        test_wrap_around();
        test_reset_mid_stream();
        test_ptr_check();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
